// File: rtl/pong_ui_pkg.sv
// Shared types and default geometry for the pong user-interface blocks.
package pong_ui_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_REQ  = 2'd2
  } serve_state_t;

  // Default paddle geometry, also used by the game-state and rendering blocks.
  localparam int unsigned DEFAULT_PY_W        = 10;
  localparam int unsigned DEFAULT_PADDLE_MAX  = 400;
  localparam int unsigned DEFAULT_PADDLE_INIT = 200;

endpackage

// File: rtl/player_input_controller_if.sv
// Signal bundle between the input synchronizer / game FSM and one player's
// input controller. The controller uses the slave modport.
interface player_input_controller_if #(
  parameter int unsigned PY_W = pong_ui_pkg::DEFAULT_PY_W
);
  logic            joystick_up;
  logic            joystick_down;
  logic            arcade_button_pressed;
  logic            serve_enable;
  logic            serve_ack;
  logic            clear_inputs;
  logic [PY_W-1:0] paddle_y;
  logic            paddle_moved;
  logic            serve_req;
  logic            arcade_led;

  modport master (
    output joystick_up, joystick_down, arcade_button_pressed,
    output serve_enable, serve_ack, clear_inputs,
    input  paddle_y, paddle_moved, serve_req, arcade_led
  );

  modport slave (
    input  joystick_up, joystick_down, arcade_button_pressed,
    input  serve_enable, serve_ack, clear_inputs,
    output paddle_y, paddle_moved, serve_req, arcade_led
  );
endinterface

// File: rtl/button_debouncer.sv
// Level debouncer: the output level follows the raw input only after the raw
// input has held a new level for CYCLES consecutive clocks. rise is a
// registered one-cycle pulse coincident with the first cycle of a high level.
module button_debouncer #(
  parameter int unsigned CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;

  // Count consecutive mismatching cycles; flip the level on the last one.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (raw != level_q) begin
      if (cnt_q == CNT_W'(CYCLES - 1)) begin
        level_d = raw;
        rise_d  = raw;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/player_input_controller.sv
// One player's input sequencer: debounced serve button, rate-limited and
// saturating paddle motion, serve request handshake and arcade LED drive.
module player_input_controller
  import pong_ui_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned MOVE_PERIOD     = 100000,
  parameter int unsigned BLINK_PERIOD    = 12500000,
  parameter int unsigned PY_W            = DEFAULT_PY_W,
  parameter int unsigned PADDLE_MAX      = DEFAULT_PADDLE_MAX,
  parameter int unsigned PADDLE_INIT     = DEFAULT_PADDLE_INIT
) (
  input  logic                      clock,
  input  logic                      reset,
  player_input_controller_if.slave  bus
);

  localparam int unsigned MOVE_W  = (MOVE_PERIOD  > 1) ? $clog2(MOVE_PERIOD)  : 1;
  localparam int unsigned BLINK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [PY_W-1:0] Y_MAX  = PY_W'(PADDLE_MAX);
  localparam logic [PY_W-1:0] Y_INIT = PY_W'(PADDLE_INIT);

  logic db_level;
  logic db_rise;
  logic press_evt;

  button_debouncer #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_serve_db (
    .clock(clock),
    .reset(reset),
    .raw  (bus.arcade_button_pressed),
    .level(db_level),
    .rise (db_rise)
  );

  // rise always coincides with a high level; qualifying on both keeps the
  // press definition tied to the debounced level itself.
  assign press_evt = db_rise && db_level;

  // ---------------- paddle ----------------
  logic [MOVE_W-1:0] move_cnt_q, move_cnt_d;
  logic [PY_W-1:0]   paddle_y_q, paddle_y_d;
  logic              paddle_moved_q, paddle_moved_d;
  logic              tick;

  assign tick = (move_cnt_q == MOVE_W'(MOVE_PERIOD - 1));

  // Step the paddle on each tick, saturating at both ends; clear overrides.
  always_comb begin
    move_cnt_d     = tick ? '0 : move_cnt_q + MOVE_W'(1);
    paddle_y_d     = paddle_y_q;
    paddle_moved_d = 1'b0;
    if (tick) begin
      if (bus.joystick_up && !bus.joystick_down && (paddle_y_q < Y_MAX)) begin
        paddle_y_d     = paddle_y_q + PY_W'(1);
        paddle_moved_d = 1'b1;
      end else if (bus.joystick_down && !bus.joystick_up && (paddle_y_q != '0)) begin
        paddle_y_d     = paddle_y_q - PY_W'(1);
        paddle_moved_d = 1'b1;
      end
    end
    if (bus.clear_inputs) begin
      move_cnt_d     = '0;
      paddle_y_d     = Y_INIT;
      paddle_moved_d = 1'b0;
    end
  end

  // Paddle registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      move_cnt_q     <= '0;
      paddle_y_q     <= Y_INIT;
      paddle_moved_q <= 1'b0;
    end else begin
      move_cnt_q     <= move_cnt_d;
      paddle_y_q     <= paddle_y_d;
      paddle_moved_q <= paddle_moved_d;
    end
  end

  // ---------------- serve FSM ----------------
  serve_state_t       state_q, state_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               led_q, led_d;
  logic               serve_req_q, serve_req_d;

  // Next state by priority: clear, ack (only meaningful in S_REQ), the rest.
  // Outputs are derived from the next state so they register alongside it.
  always_comb begin
    state_d     = state_q;
    blink_cnt_d = '0;
    led_d       = 1'b0;
    serve_req_d = 1'b0;

    if (bus.clear_inputs) begin
      state_d = S_IDLE;
    end else if (bus.serve_ack && (state_q == S_REQ)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (bus.serve_enable) state_d = S_WAIT;
        S_WAIT: begin
          if (!bus.serve_enable) state_d = S_IDLE;
          else if (press_evt)    state_d = S_REQ;
        end
        S_REQ:   state_d = S_REQ;
        default: state_d = S_IDLE;
      endcase
    end

    case (state_d)
      S_WAIT: begin
        if (state_q != S_WAIT) begin
          led_d       = 1'b1;
          blink_cnt_d = '0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_PERIOD - 1)) begin
          led_d       = ~led_q;
          blink_cnt_d = '0;
        end else begin
          led_d       = led_q;
          blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end
      end
      S_REQ: begin
        led_d       = 1'b1;
        serve_req_d = 1'b1;
      end
      default: begin
        led_d       = 1'b0;
        serve_req_d = 1'b0;
      end
    endcase
  end

  // Serve FSM state and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      blink_cnt_q <= '0;
      led_q       <= 1'b0;
      serve_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      blink_cnt_q <= blink_cnt_d;
      led_q       <= led_d;
      serve_req_q <= serve_req_d;
    end
  end

  assign bus.paddle_y     = paddle_y_q;
  assign bus.paddle_moved = paddle_moved_q;
  assign bus.serve_req    = serve_req_q;
  assign bus.arcade_led   = led_q;

endmodule

// File: tb/tb_player_input_controller.sv
// Directed bench for player_input_controller with small parameters.
module tb_player_input_controller;

  localparam int unsigned PY_W = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  player_input_controller_if #(.PY_W(PY_W)) bus ();

  player_input_controller #(
    .DEBOUNCE_CYCLES(4),
    .MOVE_PERIOD    (8),
    .BLINK_PERIOD   (16),
    .PY_W           (PY_W),
    .PADDLE_MAX     (15),
    .PADDLE_INIT    (7)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        up;
    logic        down;
    int unsigned steps;
    logic [3:0]  y;
    logic        moved;
  } pad_vec_t;

  pad_vec_t vecs[$];

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive_idle();
    bus.joystick_up           = 1'b0;
    bus.joystick_down         = 1'b0;
    bus.arcade_button_pressed = 1'b0;
    bus.serve_enable          = 1'b0;
    bus.serve_ack             = 1'b0;
    bus.clear_inputs          = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Paddle table: up for 80 cycles (7..15 then saturated), both held,
    // down, both, down to 0 and saturated there.
    vecs.push_back('{1'b1, 1'b0, 8, 4'd8,  1'b1});
    vecs.push_back('{1'b1, 1'b0, 1, 4'd8,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 7, 4'd9,  1'b1});
    vecs.push_back('{1'b1, 1'b0, 1, 4'd9,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 7, 4'd10, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1, 4'd10, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 7, 4'd11, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1, 4'd11, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 7, 4'd12, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1, 4'd12, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 7, 4'd13, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1, 4'd13, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 7, 4'd14, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1, 4'd14, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 7, 4'd15, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1, 4'd15, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 7, 4'd15, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1, 4'd15, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 7, 4'd15, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 8, 4'd15, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8, 4'd14, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 8, 4'd14, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 112, 4'd0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8, 4'd0,  1'b0});

    // Reset with random inputs.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.joystick_up           = 1'($urandom_range(1));
      bus.joystick_down         = 1'($urandom_range(1));
      bus.arcade_button_pressed = 1'($urandom_range(1));
      bus.serve_enable          = 1'($urandom_range(1));
      bus.serve_ack             = 1'($urandom_range(1));
      bus.clear_inputs          = 1'($urandom_range(1));
      step(1);
    end
    check("reset_paddle_y", 32'(bus.paddle_y), 7);
    check("reset_serve_req", 32'(bus.serve_req), 0);
    check("reset_led", 32'(bus.arcade_led), 0);
    check("reset_moved", 32'(bus.paddle_moved), 0);
    drive_idle();
    reset = 1'b1;

    // Paddle vectors.
    foreach (vecs[i]) begin
      bus.joystick_up   = vecs[i].up;
      bus.joystick_down = vecs[i].down;
      step(vecs[i].steps);
      check($sformatf("pad%0d_y", i), 32'(bus.paddle_y), 32'(vecs[i].y));
      check($sformatf("pad%0d_moved", i), 32'(bus.paddle_moved), 32'(vecs[i].moved));
    end
    bus.joystick_up   = 1'b0;
    bus.joystick_down = 1'b0;

    // Blink in S_WAIT.
    bus.serve_enable = 1'b1;
    step(1);
    check("blink_entry_led", 32'(bus.arcade_led), 1);
    step(15);
    check("blink_hold_led", 32'(bus.arcade_led), 1);
    step(1);
    check("blink_toggle1_led", 32'(bus.arcade_led), 0);
    step(15);
    check("blink_hold0_led", 32'(bus.arcade_led), 0);
    step(1);
    check("blink_toggle2_led", 32'(bus.arcade_led), 1);
    check("blink_req", 32'(bus.serve_req), 0);

    // Glitch of 3 cycles, with serve_ack asserted outside S_REQ.
    bus.arcade_button_pressed = 1'b1;
    bus.serve_ack = 1'b1;
    step(3);
    bus.arcade_button_pressed = 1'b0;
    bus.serve_ack = 1'b0;
    step(4);
    check("glitch_req", 32'(bus.serve_req), 0);

    // Valid press: serve_req one cycle after the debounced rise.
    bus.arcade_button_pressed = 1'b1;
    step(3);
    check("press_pre_req", 32'(bus.serve_req), 0);
    step(1);
    check("press_rise_req", 32'(bus.serve_req), 0);
    step(1);
    check("press_req", 32'(bus.serve_req), 1);
    check("press_led", 32'(bus.arcade_led), 1);
    bus.serve_enable = 1'b0;
    step(20);
    check("req_hold_req", 32'(bus.serve_req), 1);
    check("req_solid_led", 32'(bus.arcade_led), 1);
    bus.serve_ack = 1'b1;
    step(1);
    bus.serve_ack = 1'b0;
    check("ack_req", 32'(bus.serve_req), 0);
    check("ack_led", 32'(bus.arcade_led), 0);
    bus.arcade_button_pressed = 1'b0;
    step(5);

    // press_evt and serve_enable falling in the same cycle.
    bus.serve_enable = 1'b1;
    step(1);
    bus.arcade_button_pressed = 1'b1;
    step(4);
    bus.serve_enable = 1'b0;
    step(1);
    check("simul_req", 32'(bus.serve_req), 0);
    check("simul_led", 32'(bus.arcade_led), 0);
    bus.serve_enable = 1'b1;
    step(3);
    check("simul_reenable_req", 32'(bus.serve_req), 0);
    check("simul_reenable_led", 32'(bus.arcade_led), 1);
    bus.arcade_button_pressed = 1'b0;
    bus.serve_enable = 1'b0;
    step(5);

    // clear_inputs with serve_ack in S_REQ, button held across clear.
    bus.serve_enable = 1'b1;
    step(1);
    bus.arcade_button_pressed = 1'b1;
    step(5);
    check("clr_pre_req", 32'(bus.serve_req), 1);
    bus.clear_inputs = 1'b1;
    bus.serve_ack    = 1'b1;
    step(1);
    bus.clear_inputs = 1'b0;
    bus.serve_ack    = 1'b0;
    bus.joystick_up  = 1'b1;
    check("clr_req", 32'(bus.serve_req), 0);
    check("clr_led", 32'(bus.arcade_led), 0);
    check("clr_paddle_y", 32'(bus.paddle_y), 7);
    step(7);
    check("clr_move_pre_y", 32'(bus.paddle_y), 7);
    step(1);
    check("clr_move_y", 32'(bus.paddle_y), 8);
    check("clr_move_moved", 32'(bus.paddle_moved), 1);
    bus.joystick_up = 1'b0;
    check("held_req_a", 32'(bus.serve_req), 0);
    step(10);
    check("held_req_b", 32'(bus.serve_req), 0);
    bus.arcade_button_pressed = 1'b0;
    step(5);
    bus.arcade_button_pressed = 1'b1;
    step(4);
    check("repress_rise_req", 32'(bus.serve_req), 0);
    step(1);
    check("repress_req", 32'(bus.serve_req), 1);
    bus.serve_ack = 1'b1;
    step(1);
    bus.serve_ack = 1'b0;
    check("repress_ack_req", 32'(bus.serve_req), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
